clarvi_led_sequencer: RTL and testbench
=======================================

Name: clarvi_led_sequencer

Overview:
- Autonomous pattern sequencer for the 10-bit LED PIO.
- Software loads up to DEPTH patterns, a step period and a length through an Avalon-MM slave. It then sets enable.
- The block acts as the single writer on the LED PIO's s1 port. It issues one zero-wait write per step, so the CPU no longer bit-bangs LED animations.
- Sits between the CPU data bus (config slave) and the LED PIO (master side).

Parameters:
- DEPTH, 8: number of pattern table entries (power of two, max 8).
- LED_WIDTH, 10: width of each pattern; zero-extended to 32 bits on the PIO write.
- DIV_WIDTH, 24: width of the step period counter.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  reset, asynchronous assert, active-low.
- address  in  4  config slave word address.
- chipselect  in  1  config slave select.
- write_n  in  1  config slave write strobe, active-low.
- writedata  in  32  config slave write data.
- readdata  out  32  config slave read data; combinational from address, zero wait states.
- led_address  out  2  PIO address; constant 0.
- led_chipselect  out  1  PIO select.
- led_write_n  out  1  PIO write strobe, active-low.
- led_writedata  out  32  PIO write data.
- busy  out  1  high while the sequencer is not IDLE/DONE.

Behaviour:
- Interface: one clock, clk. Reset is asynchronous and active-low, reset_n.
- Register map (slave write takes effect when chipselect && !write_n):
  - 0 CTRL: bit0 enable, bit1 loop.
  - 1 STATUS (RO): bit0 busy, bit1 done (sticky), bits[6:4] current index.
  - 2 PERIOD: DIV_WIDTH bits.
  - 3 LENGTH: 4 bits.
  - 8..8+DEPTH-1: pattern entries, LED_WIDTH bits.
  - Unmapped addresses read 0; writes to them are ignored. Reads return zero-extended values.
- Reset values: CTRL=0, PERIOD=0, LENGTH=0, table=0, index=0, done=0, state IDLE.
- Reset outputs: led_chipselect=0, led_write_n=1, led_writedata=0, led_address=0, busy=0.
- Effective values:
  - eff_period = max(PERIOD,1).
  - eff_len = LENGTH==0 ? 1 : min(LENGTH,DEPTH).
- FSM states: IDLE, LOAD, WAIT, DONE.
- A CTRL write with enable=1, in any state:
  - index←0, done←0, counter cleared.
  - Next state LOAD (a restart if already running).
- A CTRL write with enable=0: next state IDLE. No further PIO writes; LEDs hold their last value.
- LOAD, exactly one cycle:
  - led_chipselect=1, led_write_n=0, led_writedata={0, table[index]}.
  - The PIO captures at the end of this cycle.
  - Then, if eff_period==1, advance immediately; else go to WAIT with counter=eff_period-2.
- WAIT: decrement counter each cycle. At 0, advance.
- Advance:
  - If index+1 < eff_len: index++, go LOAD.
  - Else if loop: index←0, go LOAD.
  - Else go DONE: done←1, CTRL.enable←0.
- Consecutive PIO write pulses are spaced exactly eff_period cycles apart.
- Latency: the first write pulse occurs in the cycle after the clock edge that captured the enable write.
- DONE behaves like IDLE except done=1. busy=1 only in LOAD/WAIT.
- PIO strobes must be registered (glitch-free). led_chipselect and !led_write_n are high only in LOAD.
- Mid-run writes:
  - A table write takes effect the next time that entry is loaded.
  - A PERIOD write takes effect at the next LOAD.
  - A LENGTH write is re-evaluated at each advance. If index+1 ≥ new eff_len, the advance wraps (loop) or finishes (no loop).
- Simultaneous slave CTRL write and advance: the CTRL write wins.
- reset_n low mid-operation: immediate return to reset values, including any PIO strobe in flight (deasserted asynchronously).

Test Plan:
- Reset, then table[0..2]=0x001,0x002,0x004, LENGTH=3, PERIOD=4, CTRL=0x1 -> three PIO writes with data 0x1,0x2,0x4 at cycles T+1, T+5, T+9. Then STATUS=0x2 (done), busy=0, CTRL reads 0.
- Same setup with CTRL=0x3 (loop) -> writes repeat 0x1,0x2,0x4,0x1,... every 4 cycles. STATUS index cycles 0,1,2 while running.
- PERIOD=0, LENGTH=0, table[0]=0x3FF, CTRL=0x1 -> exactly one write of 0x3FF one cycle after enable. Then done=1.
- Loop running with PERIOD=1, LENGTH=9 -> eff_len 8. A write pulse occurs on every consecutive cycle, data table[0..7] repeating.
- Looping run, write CTRL=0x0 during WAIT -> no further PIO writes, busy=0 next cycle. Write CTRL=0x3 -> restarts at table[0].
- Assert reset_n low during a LOAD cycle -> led_chipselect=0 and led_write_n=1 immediately, all registers return to reset values, no write completes after release.

Source files
------------

// File: rtl/clarvi_led_sequencer_if.sv
// Bus bundle for the LED sequencer: CPU config slave plus the LED PIO write port.
// The "slave" modport is the sequencer's view and "master" is the CPU/PIO-side view.
interface clarvi_led_sequencer_if;
  logic [3:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic [1:0]  led_address;
  logic        led_chipselect;
  logic        led_write_n;
  logic [31:0] led_writedata;

  modport slave (
    input  address, chipselect, write_n, writedata,
    output readdata, led_address, led_chipselect, led_write_n, led_writedata
  );

  modport master (
    output address, chipselect, write_n, writedata,
    input  readdata, led_address, led_chipselect, led_write_n, led_writedata
  );
endinterface

// File: rtl/clarvi_led_sequencer.sv
// Autonomous LED pattern sequencer: a config slave loads a pattern table, and the block
// then issues one registered zero-wait PIO write per step period.
module clarvi_led_sequencer #(
  parameter int DEPTH     = 8,
  parameter int LED_WIDTH = 10,
  parameter int DIV_WIDTH = 24
) (
  input  logic                   clk,
  input  logic                   reset_n,
  clarvi_led_sequencer_if.slave  bus,
  output logic                   busy
);

  typedef enum logic [1:0] {IDLE, LOAD, WAIT, DONE} state_t;

  localparam logic [3:0] DEPTH_L = 4'(DEPTH);

  state_t                 state_reg, state_next;
  logic                   enable_reg, enable_next;
  logic                   loop_reg;
  logic [DIV_WIDTH-1:0]   period_reg;
  logic [DIV_WIDTH-1:0]   count_reg, count_next;
  logic [DIV_WIDTH-1:0]   eff_period;
  logic [3:0]             length_reg;
  logic [3:0]             eff_len;
  logic [2:0]             index_reg, index_next;
  logic                   done_reg, done_next;
  logic [LED_WIDTH-1:0]   table_reg [DEPTH];
  logic [DEPTH-1:0]       table_we;
  logic                   led_cs_reg, led_wn_reg;
  logic [LED_WIDTH-1:0]   led_data_reg;
  logic                   cfg_wr, ctrl_wr;
  logic                   unused_wdata;

  assign cfg_wr  = bus.chipselect && !bus.write_n;
  assign ctrl_wr = cfg_wr && (bus.address == 4'd0);
  assign unused_wdata = ^bus.writedata[31:DIV_WIDTH];

  assign eff_period = (period_reg == '0) ? DIV_WIDTH'(1) : period_reg;

  always_comb begin
    eff_len = length_reg;
    if (length_reg == 4'd0)
      eff_len = 4'd1;
    else if (length_reg > DEPTH_L)
      eff_len = DEPTH_L;
  end

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_table_we
      assign table_we[gi] = cfg_wr && (bus.address == 4'(8 + gi));
    end
  endgenerate

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) table_reg[i] <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++)
        if (table_we[i]) table_reg[i] <= bus.writedata[LED_WIDTH-1:0];
    end
  end

  always_comb begin
    state_next  = state_reg;
    index_next  = index_reg;
    count_next  = count_reg;
    done_next   = done_reg;
    enable_next = enable_reg;

    case (state_reg)
      LOAD, WAIT: begin
        if (state_reg == WAIT && count_reg != '0) begin
          count_next = count_reg - DIV_WIDTH'(1);
        end else if (state_reg == LOAD && eff_period != DIV_WIDTH'(1)) begin
          state_next = WAIT;
          count_next = eff_period - DIV_WIDTH'(2);
        end else if (({1'b0, index_reg} + 4'd1) < eff_len) begin
          index_next = index_reg + 3'd1;
          state_next = LOAD;
        end else if (loop_reg) begin
          index_next = '0;
          state_next = LOAD;
        end else begin
          // Index parks at 0 so STATUS reads as a clean "done" word after a run.
          index_next  = '0;
          state_next  = DONE;
          done_next   = 1'b1;
          enable_next = 1'b0;
        end
      end
      default: ;
    endcase

    // A CTRL write overrides whatever the sequencer was about to do this cycle.
    if (ctrl_wr) begin
      enable_next = bus.writedata[0];
      if (bus.writedata[0]) begin
        index_next = '0;
        done_next  = 1'b0;
        count_next = '0;
        state_next = LOAD;
      end else begin
        state_next = IDLE;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg    <= IDLE;
      enable_reg   <= 1'b0;
      loop_reg     <= 1'b0;
      period_reg   <= '0;
      length_reg   <= '0;
      count_reg    <= '0;
      index_reg    <= '0;
      done_reg     <= 1'b0;
      led_cs_reg   <= 1'b0;
      led_wn_reg   <= 1'b1;
      led_data_reg <= '0;
    end else begin
      state_reg  <= state_next;
      enable_reg <= enable_next;
      count_reg  <= count_next;
      index_reg  <= index_next;
      done_reg   <= done_next;
      if (ctrl_wr) loop_reg <= bus.writedata[1];
      if (cfg_wr && bus.address == 4'd2) period_reg <= bus.writedata[DIV_WIDTH-1:0];
      if (cfg_wr && bus.address == 4'd3) length_reg <= bus.writedata[3:0];
      // Strobes are registered from the next state so the pulse lines up with LOAD.
      led_cs_reg <= (state_next == LOAD);
      led_wn_reg <= (state_next != LOAD);
      if (state_next == LOAD) led_data_reg <= table_reg[index_next];
    end
  end

  assign busy               = (state_reg == LOAD) || (state_reg == WAIT);
  assign bus.led_address    = 2'd0;
  assign bus.led_chipselect = led_cs_reg;
  assign bus.led_write_n    = led_wn_reg;
  assign bus.led_writedata  = {{(32-LED_WIDTH){1'b0}}, led_data_reg};

  always_comb begin
    bus.readdata = '0;
    case (bus.address)
      4'd0: bus.readdata[1:0] = {loop_reg, enable_reg};
      4'd1: bus.readdata[6:0] = {index_reg, 2'b00, done_reg, busy};
      4'd2: bus.readdata[DIV_WIDTH-1:0] = period_reg;
      4'd3: bus.readdata[3:0] = length_reg;
      default: begin
        if (bus.address[3] && ({1'b0, bus.address[2:0]} < DEPTH_L))
          bus.readdata[LED_WIDTH-1:0] = table_reg[bus.address[2:0]];
      end
    endcase
  end

endmodule

// File: tb/tb_clarvi_led_sequencer.sv
// Directed bench for clarvi_led_sequencer: programs the config slave and logs every PIO write.
module tb_clarvi_led_sequencer;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic busy;
  int   cycle = 0;
  int   tests_run = 0;
  int   tests_failed = 0;
  int   wr_cyc[$];
  logic [31:0] wr_dat[$];
  int   t0;

  clarvi_led_sequencer_if bus ();

  clarvi_led_sequencer #(.DEPTH(8), .LED_WIDTH(10), .DIV_WIDTH(24)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus),
    .busy    (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cycle <= cycle + 1;

  always @(negedge clk)
    if (bus.led_chipselect && !bus.led_write_n) begin
      wr_cyc.push_back(cycle);
      wr_dat.push_back(bus.led_writedata);
    end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end else
      $display("[TB] ok   %s: 0x%0h", tag, got);
  endtask

  task automatic cfg_write(input logic [3:0] addr, input logic [31:0] data);
    @(negedge clk);
    bus.address = addr; bus.writedata = data; bus.chipselect = 1'b1; bus.write_n = 1'b0;
    @(negedge clk);
    bus.chipselect = 1'b0; bus.write_n = 1'b1;
  endtask

  task automatic cfg_read(input string tag, input logic [3:0] addr, input logic [31:0] exp);
    @(negedge clk);
    bus.address = addr;
    #1 check(tag, bus.readdata, exp);
  endtask

  task automatic clear_log();
    wr_cyc.delete();
    wr_dat.delete();
  endtask

  // Compares logged write i against an expected cycle offset from t0 and data.
  task automatic check_wr(input int i, input int off, input logic [31:0] data);
    if (i < wr_cyc.size()) begin
      check($sformatf("wr%0d_cycle", i), 32'(wr_cyc[i] - t0), 32'(off));
      check($sformatf("wr%0d_data", i), wr_dat[i], data);
    end else
      check($sformatf("wr%0d_present", i), 32'(wr_cyc.size()), 32'(i + 1));
  endtask

  initial begin
    bus.address = '0; bus.chipselect = 1'b0; bus.write_n = 1'b1; bus.writedata = '0;
    repeat (3) @(negedge clk);
    #1 check("rst_led_cs", 32'(bus.led_chipselect), 32'd0);
    check("rst_led_wn", 32'(bus.led_write_n), 32'd1);
    check("rst_led_data", bus.led_writedata, 32'd0);
    check("rst_led_addr", 32'(bus.led_address), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    reset_n = 1'b1;
    cfg_read("rst_ctrl", 4'd0, 32'd0);
    cfg_read("rst_status", 4'd1, 32'd0);
    cfg_read("rst_period", 4'd2, 32'd0);

    // One-shot run: three patterns, period 4
    cfg_write(4'd8, 32'h001); cfg_write(4'd9, 32'h002); cfg_write(4'd10, 32'h004);
    cfg_write(4'd3, 32'd3);   cfg_write(4'd2, 32'd4);
    cfg_read("tbl2_read", 4'd10, 32'h004);
    clear_log();
    cfg_write(4'd0, 32'h1);
    t0 = cycle;
    #1 check("run_busy", 32'(busy), 32'd1);
    repeat (15) @(negedge clk);
    check("oneshot_count", 32'(wr_cyc.size()), 32'd3);
    check_wr(0, 0, 32'h1); check_wr(1, 4, 32'h2); check_wr(2, 8, 32'h4);
    cfg_read("oneshot_status", 4'd1, 32'h2);
    check("oneshot_busy", 32'(busy), 32'd0);
    cfg_read("oneshot_ctrl", 4'd0, 32'd0);

    // Looping run with STATUS index sampling, then stop during WAIT
    clear_log();
    cfg_write(4'd0, 32'h3);
    t0 = cycle;
    bus.address = 4'd1;
    for (int k = 1; k <= 17; k++) begin
      @(negedge clk);
      #1;
      if (k == 6)  check("loop_status_k6", bus.readdata, 32'h11);
      if (k == 10) check("loop_status_k10", bus.readdata, 32'h21);
      if (k == 13) check("loop_status_k13", bus.readdata, 32'h01);
    end
    check("loop_count", 32'(wr_cyc.size()), 32'd5);
    check_wr(0, 0, 32'h1); check_wr(1, 4, 32'h2); check_wr(2, 8, 32'h4);
    check_wr(3, 12, 32'h1); check_wr(4, 16, 32'h2);
    clear_log();
    cfg_write(4'd0, 32'h0);
    #1 check("stop_busy", 32'(busy), 32'd0);
    repeat (10) @(negedge clk);
    check("stop_no_writes", 32'(wr_cyc.size()), 32'd0);
    check("stop_led_hold", bus.led_writedata, 32'h2);
    clear_log();
    cfg_write(4'd0, 32'h3);
    t0 = cycle;
    @(negedge clk);
    check_wr(0, 0, 32'h1);
    cfg_write(4'd0, 32'h0);

    // Minimum period and length
    cfg_write(4'd2, 32'd0); cfg_write(4'd3, 32'd0); cfg_write(4'd8, 32'h3FF);
    clear_log();
    cfg_write(4'd0, 32'h1);
    t0 = cycle;
    repeat (10) @(negedge clk);
    check("min_count", 32'(wr_cyc.size()), 32'd1);
    check_wr(0, 0, 32'h3FF);
    cfg_read("min_status", 4'd1, 32'h2);

    // Back-to-back writes, LENGTH clamps to DEPTH
    for (int k = 0; k < 8; k++) cfg_write(4'(8 + k), 32'(16 + k));
    cfg_write(4'd2, 32'd1); cfg_write(4'd3, 32'd9);
    clear_log();
    cfg_write(4'd0, 32'h3);
    t0 = cycle;
    repeat (20) @(negedge clk);
    cfg_write(4'd0, 32'h0);
    for (int i = 0; i < 16; i++) check_wr(i, i, 32'(16 + (i % 8)));
    cfg_read("len_readback", 4'd3, 32'd9);

    // Unmapped address
    cfg_write(4'd5, 32'hFFFF_FFFF);
    cfg_read("unmapped_read", 4'd5, 32'd0);

    // Reset asserted during a LOAD cycle
    cfg_write(4'd2, 32'd4);
    cfg_write(4'd0, 32'h3);
    #1 check("pre_rst_cs", 32'(bus.led_chipselect), 32'd1);
    reset_n = 1'b0;
    #1 check("rst_mid_cs", 32'(bus.led_chipselect), 32'd0);
    check("rst_mid_wn", 32'(bus.led_write_n), 32'd1);
    check("rst_mid_busy", 32'(busy), 32'd0);
    check("rst_mid_data", bus.led_writedata, 32'd0);
    clear_log();
    @(negedge clk);
    reset_n = 1'b1;
    repeat (10) @(negedge clk);
    check("rst_no_writes", 32'(wr_cyc.size()), 32'd0);
    cfg_read("rst_ctrl2", 4'd0, 32'd0);
    cfg_read("rst_period2", 4'd2, 32'd0);
    cfg_read("rst_table0", 4'd8, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
